branch_predictor_table: RTL

Parametrised PC-indexed branch direction predictor. It replaces the single global 2-bit counter with a pattern history table (PHT) of saturating counters. The table is indexed either by PC alone (bimodal) or by PC XOR a global history register (gshare). It sits between ID, where the lookup happens and drives predicted-taken flush, and EX, where branches resolve and the update happens. It also exports performance counters for branches resolved and mispredictions.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_sat_counter.sv | 36 +++
 rtl/branch_predictor_table.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and saturating-counter helpers for the branch predictor
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    // Weakly-taken value: only the MSB of a cnt_bits-wide counter set.
    function automatic logic [31:0] bp_wt(input int cnt_bits);
        return 32'd1 << (cnt_bits - 1);
    endfunction

    // One saturating step of a width-bit counter held in the low bits of cnt.
    function automatic logic [31:0] sat_step(input logic [31:0] cnt, input logic up, input int width);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - width);
        if (up) begin
            return (cnt >= max_v) ? cnt : cnt + 32'd1;
        end
        return (cnt == 32'd0) ? cnt : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - enable-gated up/down saturating counter
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int                WIDTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [31:0]      step_full;

    // Next value: one saturating step in the requested direction.
    always_comb begin
        step_full = sat_step(32'(cnt_q), up_i, WIDTH);
        cnt_d     = step_full[WIDTH-1:0];
    end

    // Counter register; only moves when enabled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= RESET_VAL;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_table.sv
// rtl/branch_predictor_table.sv - PC/gshare-indexed PHT of saturating counters with perf counters
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2,
    parameter int HIST_BITS = 4,
    parameter int MODE      = 0,
    parameter int PERF_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lookup_valid_i,
    input  logic [31:0]          lookup_pc_i,
    output logic                 predict_o,
    output logic [IDX_BITS-1:0]  lookup_idx_o,
    input  logic                 update_i,
    input  logic [IDX_BITS-1:0]  update_idx_i,
    input  logic                 update_pred_i,
    input  logic                 result_i,
    output logic [PERF_BITS-1:0] branch_cnt_o,
    output logic [PERF_BITS-1:0] mispredict_cnt_o
);

    localparam int                 NUM_ENTRIES = 1 << IDX_BITS;
    localparam logic [31:0]        WT_FULL     = bp_wt(CNT_BITS);
    localparam logic [CNT_BITS-1:0] WT         = WT_FULL[CNT_BITS-1:0];

    generate
        if (HIST_BITS > IDX_BITS || HIST_BITS < 1 || (MODE != BP_MODE_BIMODAL && MODE != BP_MODE_GSHARE)) begin : g_bad_cfg
            $fatal(1, "branch_predictor_table: illegal HIST_BITS/MODE configuration");
        end
    endgenerate

    logic [IDX_BITS-1:0]  base_idx;
    logic [IDX_BITS-1:0]  lookup_idx;
    logic [HIST_BITS-1:0] ghr;
    logic [CNT_BITS-1:0]  pht_cnt [NUM_ENTRIES];
    logic [CNT_BITS-1:0]  sel_cnt;
    logic                 unused_pc;

    assign base_idx  = lookup_pc_i[IDX_BITS+1:2];
    assign unused_pc = ^{lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0]};

    generate
        if (MODE == BP_MODE_GSHARE) begin : g_ghr
            logic [HIST_BITS-1:0] ghr_q;
            logic [HIST_BITS-1:0] ghr_d;

            // Shift the resolved outcome into the history on every update.
            always_comb begin
                ghr_d = ghr_q;
                if (update_i) begin
                    if (HIST_BITS == 1) begin
                        ghr_d = HIST_BITS'(result_i);
                    end else begin
                        ghr_d = {ghr_q[(HIST_BITS > 1 ? HIST_BITS-2 : 0):0], result_i};
                    end
                end
            end

            // History register.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    ghr_q <= '0;
                end else begin
                    ghr_q <= ghr_d;
                end
            end

            assign ghr = ghr_q;
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

    assign lookup_idx = base_idx ^ IDX_BITS'(ghr);

    // Pattern history table: one counter per entry, updated only when selected.
    generate
        for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_pht
            bp_sat_counter #(
                .WIDTH     (CNT_BITS),
                .RESET_VAL (WT)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (update_i && (update_idx_i == IDX_BITS'(k))),
                .up_i  (result_i),
                .cnt_o (pht_cnt[k])
            );
        end
    endgenerate

    // No bypass: a same-cycle update is only seen after the clock edge.
    assign sel_cnt      = pht_cnt[lookup_idx];
    assign predict_o    = lookup_valid_i & sel_cnt[CNT_BITS-1];
    assign lookup_idx_o = lookup_idx;

    bp_sat_counter #(
        .WIDTH     (PERF_BITS),
        .RESET_VAL ('0)
    ) u_branch_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (update_i),
        .up_i  (1'b1),
        .cnt_o (branch_cnt_o)
    );

    bp_sat_counter #(
        .WIDTH     (PERF_BITS),
        .RESET_VAL ('0)
    ) u_mispredict_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (update_i && (update_pred_i != result_i)),
        .up_i  (1'b1),
        .cnt_o (mispredict_cnt_o)
    );

endmodule
